// File: rtl/sprite_line_buffer_if.sv
// Renderer, composer and status signals of the sprite line buffer.
// The master drives the renderer/composer requests; the slave is the buffer itself.
interface sprite_line_buffer_if #(
  parameter int AW = 10,
  parameter int DW = 16
);
  logic          line_render_start;
  logic [AW-1:0] linebuf_rdidx;
  logic [DW-1:0] linebuf_rddata;
  logic [AW-1:0] linebuf_wridx;
  logic [DW-1:0] linebuf_wrdata;
  logic          linebuf_wren;
  logic          disp_rden;
  logic [AW-1:0] disp_idx;
  logic [DW-1:0] disp_rddata;
  logic          render_bank;
  logic          clear_busy;
  logic          clear_overrun;

  modport master (
    output line_render_start, linebuf_rdidx, linebuf_wridx, linebuf_wrdata,
           linebuf_wren, disp_rden, disp_idx,
    input  linebuf_rddata, disp_rddata, render_bank, clear_busy, clear_overrun
  );

  modport slave (
    input  line_render_start, linebuf_rdidx, linebuf_wridx, linebuf_wrdata,
           linebuf_wren, disp_rden, disp_idx,
    output linebuf_rddata, disp_rddata, render_bank, clear_busy, clear_overrun
  );
endinterface

// File: rtl/sprite_line_buffer.sv
// Ping-pong sprite line buffer: render bank with RMW port, display bank with
// clear-on-read, plus init and tail sweeps that keep every bank blank on reuse.
module sprite_line_buffer #(
  parameter int DEPTH       = 1024,
  parameter int CLEAR_START = 640
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sprite_line_buffer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = 16;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_TAIL} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic          render_bank_q, render_bank_d;
  logic          overrun_q, overrun_d;
  logic          cor_pend_q, cor_bank_q;
  logic [AW-1:0] cor_idx_q;
  logic [DW-1:0] linebuf_rddata_q, disp_rddata_q;

  logic [DW-1:0] mem0 [DEPTH];
  logic [DW-1:0] mem1 [DEPTH];

  logic          disp_bank, in_init, cor_hits_disp, cor_hits_render;
  logic          sweep_go, ren_we;
  logic          we    [2];
  logic [AW-1:0] widx  [2];
  logic [DW-1:0] wdata [2];
  logic [AW-1:0] rd_addr0, rd_addr1;
  logic [DW-1:0] rd0, rd1, ren_rd, disp_rd;

  assign disp_bank       = ~render_bank_q;
  assign in_init         = (state_q == S_INIT);
  assign cor_hits_disp   = cor_pend_q && (cor_bank_q == disp_bank);
  assign cor_hits_render = cor_pend_q && (cor_bank_q == render_bank_q);
  // A pending clear-on-read owns the display bank's write port, so the sweep waits.
  assign sweep_go        = (state_q == S_TAIL) && !cor_hits_disp;
  assign ren_we          = bus.linebuf_wren && !in_init && !cor_hits_render;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      we[b]    = 1'b0;
      widx[b]  = '0;
      wdata[b] = '0;
      if (in_init) begin
        we[b]   = 1'b1;
        widx[b] = clr_cnt_q;
      end else if (cor_pend_q && cor_bank_q == 1'(b)) begin
        we[b]   = 1'b1;
        widx[b] = cor_idx_q;
      end else if (sweep_go && disp_bank == 1'(b)) begin
        we[b]   = 1'b1;
        widx[b] = clr_cnt_q;
      end else if (ren_we && render_bank_q == 1'(b)) begin
        we[b]    = 1'b1;
        widx[b]  = bus.linebuf_wridx;
        wdata[b] = bus.linebuf_wrdata;
      end
    end
  end

  // NOTE: the RAM arrays carry no reset; the INIT sweep blanks them instead.
  always_ff @(posedge clk) begin
    if (we[0]) mem0[widx[0]] <= wdata[0];
    if (we[1]) mem1[widx[1]] <= wdata[1];
  end

  // One read port per bank, steered by which role the bank currently holds.
  assign rd_addr0 = render_bank_q ? bus.disp_idx : bus.linebuf_rdidx;
  assign rd_addr1 = render_bank_q ? bus.linebuf_rdidx : bus.disp_idx;
  assign rd0      = mem0[rd_addr0];
  assign rd1      = mem1[rd_addr1];
  assign ren_rd   = render_bank_q ? rd1 : rd0;
  assign disp_rd  = render_bank_q ? rd0 : rd1;

  always_comb begin
    state_d       = state_q;
    clr_cnt_d     = clr_cnt_q;
    render_bank_d = render_bank_q;
    overrun_d     = overrun_q;
    unique case (state_q)
      S_INIT: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == AW'(DEPTH - 1)) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (bus.line_render_start) begin
          render_bank_d = ~render_bank_q;
          clr_cnt_d     = AW'(CLEAR_START);
          state_d       = S_TAIL;
        end
      end
      S_TAIL: begin
        if (bus.line_render_start) begin
          render_bank_d = ~render_bank_q;
          overrun_d     = 1'b1;
          clr_cnt_d     = AW'(CLEAR_START);
        end else if (sweep_go) begin
          clr_cnt_d = clr_cnt_q + 1'b1;
          if (clr_cnt_q == AW'(DEPTH - 1)) state_d = S_IDLE;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_INIT;
      clr_cnt_q     <= '0;
      render_bank_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      render_bank_q <= render_bank_d;
      overrun_q     <= overrun_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      linebuf_rddata_q <= '0;
      disp_rddata_q    <= '0;
      cor_pend_q       <= 1'b0;
      cor_bank_q       <= 1'b0;
      cor_idx_q        <= '0;
    end else begin
      if (in_init)
        linebuf_rddata_q <= '0;
      else if (ren_we && bus.linebuf_wridx == bus.linebuf_rdidx)
        linebuf_rddata_q <= bus.linebuf_wrdata;
      else
        linebuf_rddata_q <= ren_rd;
      // A read hitting the index still waiting to be cleared must already see zero.
      if (bus.disp_rden) begin
        if (in_init || (cor_hits_disp && cor_idx_q == bus.disp_idx))
          disp_rddata_q <= '0;
        else
          disp_rddata_q <= disp_rd;
      end
      cor_pend_q <= bus.disp_rden && !in_init;
      cor_bank_q <= disp_bank;
      cor_idx_q  <= bus.disp_idx;
    end
  end

  assign bus.linebuf_rddata = linebuf_rddata_q;
  assign bus.disp_rddata    = disp_rddata_q;
  assign bus.render_bank    = render_bank_q;
  assign bus.clear_busy     = (state_q != S_IDLE);
  assign bus.clear_overrun  = overrun_q;
endmodule

// File: tb/tb_sprite_line_buffer.sv
// Directed bench for sprite_line_buffer: init sweep, ping-pong swap, clear-on-read,
// tail sweep with stalls, write-first bypass, overrun and mid-sweep async reset.
module tb_sprite_line_buffer;
  logic clk;
  logic rst_n;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  sprite_line_buffer_if bus ();

  sprite_line_buffer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic swap();
    bus.line_render_start = 1'b1;
    tick();
    bus.line_render_start = 1'b0;
  endtask

  task automatic wr(input logic [9:0] idx, input logic [15:0] data);
    bus.linebuf_wren   = 1'b1;
    bus.linebuf_wridx  = idx;
    bus.linebuf_wrdata = data;
    tick();
    bus.linebuf_wren   = 1'b0;
  endtask

  // Counts cycles until clear_busy drops, bounded so a stuck sweep cannot hang the run.
  task automatic wait_idle(input string name, output int n);
    n = 0;
    while (bus.clear_busy === 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    total_cnt++;
    if (bus.clear_busy !== 1'b0)
      $display("FAIL %s_timeout: clear_busy=%b after %0d cycles, expected 0", name, bus.clear_busy, n);
    else
      pass_cnt++;
  endtask

  task automatic test_reset();
    int n;
    int bad_r, bad_d, first_r, first_d;
    rst_n                 = 1'b0;
    bus.line_render_start = 1'b0;
    bus.linebuf_rdidx     = '0;
    bus.linebuf_wridx     = '0;
    bus.linebuf_wrdata    = '0;
    bus.linebuf_wren      = 1'b0;
    bus.disp_rden         = 1'b0;
    bus.disp_idx          = '0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (bus.clear_busy !== 1'b1) $display("FAIL rst_busy: got %b expected 1", bus.clear_busy);
    else pass_cnt++;
    total_cnt++;
    if (bus.render_bank !== 1'b0) $display("FAIL rst_bank: got %b expected 0", bus.render_bank);
    else pass_cnt++;
    total_cnt++;
    if (bus.clear_overrun !== 1'b0) $display("FAIL rst_overrun: got %b expected 0", bus.clear_overrun);
    else pass_cnt++;
    total_cnt++;
    if (bus.linebuf_rddata !== 16'h0000) $display("FAIL rst_rddata: got %h expected 0000", bus.linebuf_rddata);
    else pass_cnt++;
    total_cnt++;
    if (bus.disp_rddata !== 16'h0000) $display("FAIL rst_disp: got %h expected 0000", bus.disp_rddata);
    else pass_cnt++;

    rst_n = 1'b1;
    wait_idle("init", n);
    total_cnt++;
    if (n !== 1024) $display("FAIL init_len: got %0d cycles expected 1024", n);
    else pass_cnt++;

    bad_r = 0; bad_d = 0; first_r = -1; first_d = -1;
    bus.disp_rden = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      bus.linebuf_rdidx = 10'(i);
      bus.disp_idx      = 10'(i);
      tick();
      if (bus.linebuf_rddata !== 16'h0000) begin bad_r++; if (first_r < 0) first_r = i; end
      if (bus.disp_rddata !== 16'h0000) begin bad_d++; if (first_d < 0) first_d = i; end
    end
    bus.disp_rden = 1'b0;
    total_cnt++;
    if (bad_r !== 0) $display("FAIL blank_bank0: %0d nonzero entries (first idx %0d), expected 0", bad_r, first_r);
    else pass_cnt++;
    total_cnt++;
    if (bad_d !== 0) $display("FAIL blank_bank1: %0d nonzero entries (first idx %0d), expected 0", bad_d, first_d);
    else pass_cnt++;
    total_cnt++;
    if (bus.render_bank !== 1'b0) $display("FAIL init_bank: got %b expected 0", bus.render_bank);
    else pass_cnt++;
  endtask

  task automatic test_render_disp();
    int n;
    wr(10'd100, 16'h3A55);
    wr(10'd101, 16'h7777);
    swap();
    total_cnt++;
    if (bus.render_bank !== 1'b1) $display("FAIL swap_bank: got %b expected 1", bus.render_bank);
    else pass_cnt++;

    bus.disp_rden = 1'b1;
    bus.disp_idx  = 10'd100;
    tick();
    total_cnt++;
    if (bus.disp_rddata !== 16'h3A55) $display("FAIL disp_read: got %h expected 3a55", bus.disp_rddata);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus.disp_rddata !== 16'h0000) $display("FAIL disp_b2b_clear: got %h expected 0000", bus.disp_rddata);
    else pass_cnt++;
    bus.disp_idx = 10'd101;
    tick();
    bus.disp_rden = 1'b0;
    total_cnt++;
    if (bus.disp_rddata !== 16'h7777) $display("FAIL disp_read2: got %h expected 7777", bus.disp_rddata);
    else pass_cnt++;
    repeat (2) tick();
    total_cnt++;
    if (bus.disp_rddata !== 16'h7777) $display("FAIL disp_hold: got %h expected 7777", bus.disp_rddata);
    else pass_cnt++;
    bus.disp_rden = 1'b1;
    bus.disp_idx  = 10'd100;
    tick();
    bus.disp_rden = 1'b0;
    total_cnt++;
    if (bus.disp_rddata !== 16'h0000) $display("FAIL disp_cleared: got %h expected 0000", bus.disp_rddata);
    else pass_cnt++;
    wait_idle("rd_tail", n);
  endtask

  task automatic test_tail_sweep();
    int n;
    wr(10'd900, 16'h1234);
    swap();
    wait_idle("tail", n);
    total_cnt++;
    if (n !== 384) $display("FAIL tail_len: got %0d cycles expected 384", n);
    else pass_cnt++;
    swap();
    bus.linebuf_rdidx = 10'd900;
    tick();
    total_cnt++;
    if (bus.linebuf_rddata !== 16'h0000) $display("FAIL tail_cleared: got %h expected 0000", bus.linebuf_rddata);
    else pass_cnt++;
    wait_idle("tail2", n);
  endtask

  task automatic test_stall();
    int n, bad, first;
    wr(10'd700, 16'hAAAA);
    wr(10'd1023, 16'h5555);
    swap();
    bus.disp_rden = 1'b1;
    for (int i = 0; i < 100; i++) begin
      bus.disp_idx = 10'(i);
      tick();
    end
    bus.disp_rden = 1'b0;
    wait_idle("stall", n);
    total_cnt++;
    if (n + 100 !== 484) $display("FAIL stall_len: got %0d cycles expected 484", n + 100);
    else pass_cnt++;

    swap();
    bad = 0; first = -1;
    for (int i = 640; i < 1024; i++) begin
      bus.linebuf_rdidx = 10'(i);
      tick();
      if (bus.linebuf_rddata !== 16'h0000) begin bad++; if (first < 0) first = i; end
    end
    total_cnt++;
    if (bad !== 0) $display("FAIL stall_tail_blank: %0d nonzero entries (first idx %0d), expected 0", bad, first);
    else pass_cnt++;
    wait_idle("stall2", n);
  endtask

  task automatic test_bypass();
    bus.linebuf_rdidx = 10'd5;
    wr(10'd5, 16'hF0AA);
    total_cnt++;
    if (bus.linebuf_rddata !== 16'hF0AA) $display("FAIL bypass: got %h expected f0aa", bus.linebuf_rddata);
    else pass_cnt++;
    wr(10'd6, 16'h0BAD);
    total_cnt++;
    if (bus.linebuf_rddata !== 16'hF0AA) $display("FAIL bypass_commit: got %h expected f0aa", bus.linebuf_rddata);
    else pass_cnt++;
    bus.linebuf_rdidx = 10'd6;
    tick();
    total_cnt++;
    if (bus.linebuf_rddata !== 16'h0BAD) $display("FAIL write_commit: got %h expected 0bad", bus.linebuf_rddata);
    else pass_cnt++;
  endtask

  task automatic test_overrun();
    int n;
    swap();
    wr(10'd650, 16'hBEEF);
    wr(10'd1000, 16'hCAFE);
    repeat (198) tick();
    total_cnt++;
    if ({bus.clear_overrun, bus.clear_busy} !== 2'b01)
      $display("FAIL pre_overrun: got overrun=%b busy=%b expected 0 1", bus.clear_overrun, bus.clear_busy);
    else pass_cnt++;
    swap();
    total_cnt++;
    if ({bus.clear_overrun, bus.render_bank, bus.clear_busy} !== 3'b111)
      $display("FAIL overrun_swap: got overrun=%b bank=%b busy=%b expected 1 1 1",
               bus.clear_overrun, bus.render_bank, bus.clear_busy);
    else pass_cnt++;
    wait_idle("overrun", n);
    total_cnt++;
    if (n !== 384) $display("FAIL overrun_restart_len: got %0d cycles expected 384", n);
    else pass_cnt++;
    total_cnt++;
    if (bus.clear_overrun !== 1'b1) $display("FAIL overrun_sticky: got %b expected 1", bus.clear_overrun);
    else pass_cnt++;
    bus.disp_rden = 1'b1;
    bus.disp_idx  = 10'd650;
    tick();
    total_cnt++;
    if (bus.disp_rddata !== 16'h0000) $display("FAIL overrun_clr650: got %h expected 0000", bus.disp_rddata);
    else pass_cnt++;
    bus.disp_idx = 10'd1000;
    tick();
    bus.disp_rden = 1'b0;
    total_cnt++;
    if (bus.disp_rddata !== 16'h0000) $display("FAIL overrun_clr1000: got %h expected 0000", bus.disp_rddata);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    int n;
    swap();
    bus.linebuf_wren   = 1'b1;
    bus.linebuf_wridx  = 10'd7;
    bus.linebuf_rdidx  = 10'd7;
    bus.linebuf_wrdata = 16'h5A5A;
    bus.disp_rden      = 1'b1;
    bus.disp_idx       = 10'd5;
    tick();
    bus.linebuf_wren = 1'b0;
    bus.disp_rden    = 1'b0;
    total_cnt++;
    if (bus.linebuf_rddata !== 16'h5A5A) $display("FAIL pre_rst_rddata: got %h expected 5a5a", bus.linebuf_rddata);
    else pass_cnt++;
    total_cnt++;
    if (bus.disp_rddata !== 16'hF0AA) $display("FAIL pre_rst_disp: got %h expected f0aa", bus.disp_rddata);
    else pass_cnt++;
    repeat (50) tick();
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({bus.linebuf_rddata, bus.disp_rddata} !== 32'h0)
      $display("FAIL async_rst_data: got %h %h expected 0000 0000", bus.linebuf_rddata, bus.disp_rddata);
    else pass_cnt++;
    total_cnt++;
    if ({bus.render_bank, bus.clear_overrun, bus.clear_busy} !== 3'b001)
      $display("FAIL async_rst_status: got bank=%b overrun=%b busy=%b expected 0 0 1",
               bus.render_bank, bus.clear_overrun, bus.clear_busy);
    else pass_cnt++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_idle("reinit", n);
    total_cnt++;
    if (n !== 1024) $display("FAIL reinit_len: got %0d cycles expected 1024", n);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_render_disp();
    test_tail_sweep();
    test_stall();
    test_bypass();
    test_overrun();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
